// File: rtl/pcie_os_gen_if.sv
// Request channel and AXI-Stream symbol channel of the ordered-set generator.
//
// Handshake rule for both channels: a transfer happens on the rising clock
// edge where valid && ready are both high. The source raises valid
// independently of ready and holds its payload stable until the transfer;
// the sink may move ready freely.
interface pcie_os_gen_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 2
);
    localparam int BYTES = DATA_WIDTH / 8;

    // Request channel (LTSSM -> generator)
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_type;
    logic [7:0]            req_count;
    logic [7:0]            req_link_num;
    logic [7:0]            req_lane_num;
    logic [7:0]            req_n_fts;
    logic [7:0]            req_rate_id;
    logic [7:0]            req_train_ctl;

    // Symbol stream (generator -> scrambler/encoder)
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [BYTES-1:0]      m_axis_tkchar;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic [USER_WIDTH-1:0] m_axis_tuser;

    // Generator side
    modport master (
        input  req_valid, req_type, req_count, req_link_num, req_lane_num,
               req_n_fts, req_rate_id, req_train_ctl, m_axis_tready,
        output req_ready, m_axis_tdata, m_axis_tkchar, m_axis_tvalid,
               m_axis_tlast, m_axis_tuser
    );

    // Request source / stream sink side
    modport slave (
        output req_valid, req_type, req_count, req_link_num, req_lane_num,
               req_n_fts, req_rate_id, req_train_ctl, m_axis_tready,
        input  req_ready, m_axis_tdata, m_axis_tkchar, m_axis_tvalid,
               m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/pcie_os_gen.sv
// PCIe ordered-set generator: streams TS1/TS2/SKP/EIOS/EIEOS once, N times
// or continuously, with per-byte K flags. Symbol 0 of an ordered set sits in
// byte lane 0. Ordered sets are never truncated except by reset.
module pcie_os_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    pcie_os_gen_if.master   bus,
    input  logic            stop,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            dbg_state
);
    localparam int         BYTES     = DATA_WIDTH / 8;
    localparam logic [3:0] STEP      = 4'(BYTES);
    localparam logic [3:0] BEAT_SPAN = 4'(BYTES - 1);

    localparam logic [2:0] T_TS1   = 3'd0;
    localparam logic [2:0] T_TS2   = 3'd1;
    localparam logic [2:0] T_SKP   = 3'd2;
    localparam logic [2:0] T_EIOS  = 3'd3;
    localparam logic [2:0] T_EIEOS = 3'd4;

    localparam logic [7:0] PAD = 8'hF7;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] sym_q, sym_d;        // symbol index carried in byte lane 0
    logic [7:0] rep_q, rep_d;        // ordered sets still to send (counted mode)
    logic       stop_q, stop_d;      // sticky stop for continuous mode
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       load;

    logic [2:0] type_q;
    logic       cont_q;              // req_count was 0
    logic [7:0] link_q, lane_q, nfts_q, rate_q, ctl_q;

    logic       is_ts;
    logic [3:0] last_sym;
    logic       beat_last;
    logic       beat_fire;
    logic       finish;

    // Symbol value for a given ordered-set type and symbol index
    function automatic logic [7:0] sym_data(
        input logic [2:0] t, input logic [3:0] idx,
        input logic [7:0] link, input logic [7:0] lane, input logic [7:0] nfts,
        input logic [7:0] rate, input logic [7:0] ctl
    );
        logic [7:0] d;
        d = 8'h00;
        case (t)
            T_TS1, T_TS2: begin
                case (idx)
                    4'd0:    d = 8'hBC;
                    4'd1:    d = link;
                    4'd2:    d = lane;
                    4'd3:    d = nfts;
                    4'd4:    d = rate;
                    4'd5:    d = ctl;
                    default: d = (t == T_TS1) ? 8'h4A : 8'h45;
                endcase
            end
            T_SKP:   d = (idx == 4'd0) ? 8'hBC : 8'h1C;
            T_EIOS:  d = (idx == 4'd0) ? 8'hBC : 8'h7C;
            T_EIEOS: d = idx[0] ? 8'hFF : 8'h00;
            default: d = 8'h00;
        endcase
        return d;
    endfunction

    // K flag for a given ordered-set type and symbol index; PAD link/lane are K23.7
    function automatic logic sym_k(
        input logic [2:0] t, input logic [3:0] idx,
        input logic [7:0] link, input logic [7:0] lane
    );
        logic k;
        k = 1'b0;
        case (t)
            T_TS1, T_TS2: begin
                case (idx)
                    4'd0:    k = 1'b1;
                    4'd1:    k = (link == PAD);
                    4'd2:    k = (lane == PAD);
                    default: k = 1'b0;
                endcase
            end
            T_SKP, T_EIOS: k = 1'b1;
            default:       k = 1'b0;
        endcase
        return k;
    endfunction

    assign is_ts     = (type_q == T_TS1) || (type_q == T_TS2);
    assign last_sym  = (is_ts || type_q == T_EIEOS) ? 4'd15 : 4'd3;
    assign beat_last = (sym_q == (last_sym - BEAT_SPAN));
    assign beat_fire = (state_q == SEND) && bus.m_axis_tready;

    // State, counters, status pulses and latched request fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sym_q   <= 4'd0;
            rep_q   <= 8'd0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            type_q  <= 3'd0;
            cont_q  <= 1'b0;
            link_q  <= 8'd0;
            lane_q  <= 8'd0;
            nfts_q  <= 8'd0;
            rate_q  <= 8'd0;
            ctl_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            rep_q   <= rep_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (load) begin
                type_q <= bus.req_type;
                cont_q <= (bus.req_count == 8'd0);
                link_q <= bus.req_link_num;
                lane_q <= bus.req_lane_num;
                nfts_q <= bus.req_n_fts;
                rate_q <= bus.req_rate_id;
                ctl_q  <= bus.req_train_ctl;
            end
        end
    end

    // Next-state: accept requests in IDLE, walk symbols and repeats in SEND
    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        rep_d   = rep_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                stop_d = 1'b0;
                if (bus.req_valid) begin
                    if (bus.req_type <= T_EIEOS) begin
                        load    = 1'b1;
                        state_d = SEND;
                        sym_d   = 4'd0;
                        rep_d   = bus.req_count;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (stop && cont_q) stop_d = 1'b1;
                if (beat_fire) begin
                    if (beat_last) begin
                        // A stop seen on this very beat still ends the stream here
                        finish = cont_q ? (stop_q || stop) : (rep_q <= 8'd1);
                        sym_d  = 4'd0;
                        if (finish) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            stop_d  = 1'b0;
                        end else if (!cont_q) begin
                            rep_d = rep_q - 8'd1;
                        end
                    end else begin
                        sym_d = sym_q + STEP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat contents are a pure function of registers, so they hold while stalled
    always_comb begin
        bus.m_axis_tdata  = '0;
        bus.m_axis_tkchar = '0;
        bus.m_axis_tuser  = '0;
        bus.m_axis_tvalid = (state_q == SEND);
        bus.m_axis_tlast  = (state_q == SEND) && beat_last;
        if (state_q == SEND) begin
            for (int b = 0; b < BYTES; b++) begin
                bus.m_axis_tdata[b*8 +: 8] = sym_data(type_q, sym_q + 4'(b), link_q,
                                                      lane_q, nfts_q, rate_q, ctl_q);
                bus.m_axis_tkchar[b]       = sym_k(type_q, sym_q + 4'(b), link_q, lane_q);
            end
            if (is_ts) begin
                bus.m_axis_tuser = USER_WIDTH'({link_q != PAD,
                                                (link_q == PAD) && (lane_q == PAD)});
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign busy          = (state_q == SEND);
    assign done          = done_q;
    assign err           = err_q;
    assign dbg_state     = (state_q == SEND);

endmodule

// File: tb/tb_pcie_os_gen.sv
// Directed bench for pcie_os_gen: a 32-bit instance for most scenarios and an
// 8-bit instance for the byte-wide TS2 case.
module tb_pcie_os_gen;
    logic clk;
    logic rst;
    logic stop32, stop8;
    logic busy32, done32, err32, st32;
    logic busy8, done8, err8, st8;

    int tests_run;
    int tests_failed;

    pcie_os_gen_if #(.DATA_WIDTH(32), .USER_WIDTH(2)) if32 ();
    pcie_os_gen_if #(.DATA_WIDTH(8),  .USER_WIDTH(2)) if8 ();

    pcie_os_gen #(.DATA_WIDTH(32), .USER_WIDTH(2)) dut32 (
        .clk(clk), .rst(rst), .bus(if32), .stop(stop32),
        .busy(busy32), .done(done32), .err(err32), .dbg_state(st32)
    );

    pcie_os_gen #(.DATA_WIDTH(8), .USER_WIDTH(2)) dut8 (
        .clk(clk), .rst(rst), .bus(if8), .stop(stop8),
        .busy(busy8), .done(done8), .err(err8), .dbg_state(st8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // capture state for the 32-bit stream
    logic [31:0] cap_d[$];
    logic [3:0]  cap_k[$];
    logic        cap_l[$];
    logic [1:0]  cap_u[$];
    int          done_cnt, done_at, stall_bad, n_stalls;
    logic        ready_at_done;

    // Drive one request into the 32-bit instance; returns at the negedge after the handshake edge
    task automatic req32(input logic [2:0] t, input logic [7:0] cnt, input logic [7:0] link,
                         input logic [7:0] lane, input logic [7:0] nfts,
                         input logic [7:0] rate, input logic [7:0] ctl);
        if32.req_type      = t;
        if32.req_count     = cnt;
        if32.req_link_num  = link;
        if32.req_lane_num  = lane;
        if32.req_n_fts     = nfts;
        if32.req_rate_id   = rate;
        if32.req_train_ctl = ctl;
        if32.req_valid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if32.req_valid     = 1'b0;
    endtask

    // Record beats of the 32-bit stream until done (plus a few cycles) or the cycle budget runs out
    task automatic capture32(input int max_cyc, input bit rnd, input int stop_at);
        logic [31:0] held;
        bit          stalled;
        int          extra;
        held = '0; stalled = 0; extra = -1;
        cap_d.delete(); cap_k.delete(); cap_l.delete(); cap_u.delete();
        done_cnt = 0; done_at = -1; stall_bad = 0; n_stalls = 0; ready_at_done = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (stalled && (if32.m_axis_tvalid !== 1'b1 || if32.m_axis_tdata !== held))
                stall_bad++;
            if (rnd) if32.m_axis_tready = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            else     if32.m_axis_tready = 1'b1;
            stalled = 0;
            if (if32.m_axis_tvalid === 1'b1) begin
                if (if32.m_axis_tready) begin
                    cap_d.push_back(if32.m_axis_tdata);
                    cap_k.push_back(if32.m_axis_tkchar);
                    cap_l.push_back(if32.m_axis_tlast);
                    cap_u.push_back(if32.m_axis_tuser);
                end else begin
                    stalled = 1;
                    held    = if32.m_axis_tdata;
                    n_stalls++;
                end
            end
            if (done32 === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at       = cap_d.size();
                    ready_at_done = if32.req_ready;
                    extra         = 3;
                end
            end
            stop32 = (stop_at > 0 && cap_d.size() == stop_at) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (extra > 0) begin
                extra--;
                if (extra == 0) break;
            end
        end
        stop32 = 1'b0;
        if32.m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (if32.req_ready !== 1'b1 || if32.m_axis_tvalid !== 1'b0 || if32.m_axis_tdata !== 32'h0 ||
            if32.m_axis_tlast !== 1'b0 || if32.m_axis_tuser !== 2'b00 || if32.m_axis_tkchar !== 4'h0 ||
            busy32 !== 1'b0 || done32 !== 1'b0 || err32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: ready=%b valid=%b data=%h last=%b user=%b k=%b busy=%b done=%b err=%b, want ready=1 rest 0",
                     if32.req_ready, if32.m_axis_tvalid, if32.m_axis_tdata, if32.m_axis_tlast,
                     if32.m_axis_tuser, if32.m_axis_tkchar, busy32, done32, err32);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if32.req_ready !== 1'b1 || if32.m_axis_tvalid !== 1'b0 || if8.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: ready32=%b valid32=%b ready8=%b, want 1 0 1",
                     if32.req_ready, if32.m_axis_tvalid, if8.req_ready);
        end
    endtask

    task automatic test_ts1_pad_count2();
        logic [31:0] ed[4];
        logic [3:0]  ek[4];
        ed[0] = 32'hFFF7F7BC; ed[1] = 32'h4A4A0004; ed[2] = 32'h4A4A4A4A; ed[3] = 32'h4A4A4A4A;
        ek[0] = 4'b0111;      ek[1] = 4'b0000;      ek[2] = 4'b0000;      ek[3] = 4'b0000;
        req32(3'd0, 8'd2, 8'hF7, 8'hF7, 8'hFF, 8'h04, 8'h00);
        tests_run++;
        if (if32.m_axis_tvalid !== 1'b1 || busy32 !== 1'b1 || if32.req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ts1_latency: valid=%b busy=%b ready=%b, want 1 1 0",
                     if32.m_axis_tvalid, busy32, if32.req_ready);
        end
        capture32(60, 1'b0, 0);
        tests_run++;
        if (cap_d.size() != 8 || done_at != 8 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL ts1_beats: beats=%0d done_at=%0d done_cnt=%0d, want 8 8 1",
                     cap_d.size(), done_at, done_cnt);
        end
        for (int i = 0; i < 8 && i < cap_d.size(); i++) begin
            tests_run++;
            if (cap_d[i] !== ed[i%4] || cap_k[i] !== ek[i%4] || cap_l[i] !== (i%4 == 3) ||
                cap_u[i] !== 2'b01) begin
                tests_failed++;
                $display("FAIL ts1_beat%0d: data=%h k=%b last=%b user=%b, want data=%h k=%b last=%b user=01",
                         i, cap_d[i], cap_k[i], cap_l[i], cap_u[i], ed[i%4], ek[i%4], (i%4 == 3));
            end
        end
        tests_run++;
        if (ready_at_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL ts1_ready_after: ready at done=%b, want 1", ready_at_done);
        end
    endtask

    task automatic test_ts2_width8();
        logic [7:0] e8[16];
        logic [7:0] cd[$];
        logic       ck[$];
        logic       cl[$];
        logic [1:0] cu[$];
        int         d_at, d_cnt, extra;
        e8[0] = 8'hBC; e8[1] = 8'h00; e8[2] = 8'h03; e8[3] = 8'h10; e8[4] = 8'h02; e8[5] = 8'h08;
        for (int i = 6; i < 16; i++) e8[i] = 8'h45;
        d_at = -1; d_cnt = 0; extra = -1;
        if8.req_type = 3'd1; if8.req_count = 8'd1; if8.req_link_num = 8'h00;
        if8.req_lane_num = 8'h03; if8.req_n_fts = 8'h10; if8.req_rate_id = 8'h02;
        if8.req_train_ctl = 8'h08; if8.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if8.req_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (if8.m_axis_tvalid === 1'b1) begin
                cd.push_back(if8.m_axis_tdata);
                ck.push_back(if8.m_axis_tkchar[0]);
                cl.push_back(if8.m_axis_tlast);
                cu.push_back(if8.m_axis_tuser);
            end
            if (done8 === 1'b1) begin
                d_cnt++;
                if (d_at < 0) begin d_at = cd.size(); extra = 3; end
            end
            @(negedge clk);
            if (extra > 0) begin
                extra--;
                if (extra == 0) break;
            end
        end
        tests_run++;
        if (cd.size() != 16 || d_at != 16 || d_cnt != 1) begin
            tests_failed++;
            $display("FAIL ts2_beats: beats=%0d done_at=%0d done_cnt=%0d, want 16 16 1",
                     cd.size(), d_at, d_cnt);
        end
        for (int i = 0; i < 16 && i < cd.size(); i++) begin
            tests_run++;
            if (cd[i] !== e8[i] || ck[i] !== (i == 0) || cl[i] !== (i == 15) || cu[i] !== 2'b10) begin
                tests_failed++;
                $display("FAIL ts2_beat%0d: data=%h k=%b last=%b user=%b, want data=%h k=%b last=%b user=10",
                         i, cd[i], ck[i], cl[i], cu[i], e8[i], (i == 0), (i == 15));
            end
        end
    endtask

    task automatic test_skp_continuous_stop();
        req32(3'd2, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        capture32(60, 1'b0, 3);
        tests_run++;
        if (cap_d.size() != 3 || done_at != 3 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL skp_stop_count: beats=%0d done_at=%0d done_cnt=%0d, want 3 3 1",
                     cap_d.size(), done_at, done_cnt);
        end
        for (int i = 0; i < cap_d.size() && i < 3; i++) begin
            tests_run++;
            if (cap_d[i] !== 32'h1C1C1CBC || cap_k[i] !== 4'b1111 || cap_l[i] !== 1'b1 ||
                cap_u[i] !== 2'b00) begin
                tests_failed++;
                $display("FAIL skp_beat%0d: data=%h k=%b last=%b user=%b, want 1c1c1cbc 1111 1 00",
                         i, cap_d[i], cap_k[i], cap_l[i], cap_u[i]);
            end
        end
    endtask

    task automatic test_eieos_backpressure();
        req32(3'd4, 8'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        capture32(200, 1'b1, 0);
        tests_run++;
        if (cap_d.size() != 4 || done_at != 4 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL eieos_beats: beats=%0d done_at=%0d done_cnt=%0d, want 4 4 1",
                     cap_d.size(), done_at, done_cnt);
        end
        tests_run++;
        if (stall_bad != 0 || n_stalls == 0) begin
            tests_failed++;
            $display("FAIL eieos_hold: unstable stalls=%0d stalls seen=%0d, want 0 and >0",
                     stall_bad, n_stalls);
        end
        for (int i = 0; i < cap_d.size() && i < 4; i++) begin
            tests_run++;
            if (cap_d[i] !== 32'hFF00FF00 || cap_k[i] !== 4'b0000 || cap_l[i] !== (i == 3) ||
                cap_u[i] !== 2'b00) begin
                tests_failed++;
                $display("FAIL eieos_beat%0d: data=%h k=%b last=%b user=%b, want ff00ff00 0000 %b 00",
                         i, cap_d[i], cap_k[i], cap_l[i], cap_u[i], (i == 3));
            end
        end
    endtask

    task automatic test_invalid_type();
        req32(3'd6, 8'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        tests_run++;
        if (err32 !== 1'b1 || if32.m_axis_tvalid !== 1'b0 || if32.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL invalid_err: err=%b valid=%b ready=%b, want 1 0 1",
                     err32, if32.m_axis_tvalid, if32.req_ready);
        end
        @(negedge clk);
        tests_run++;
        if (err32 !== 1'b0 || if32.m_axis_tvalid !== 1'b0 || if32.req_ready !== 1'b1 || busy32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL invalid_after: err=%b valid=%b ready=%b busy=%b, want 0 0 1 0",
                     err32, if32.m_axis_tvalid, if32.req_ready, busy32);
        end
    endtask

    task automatic test_reset_mid_then_eios();
        if32.m_axis_tready = 1'b1;
        req32(3'd0, 8'd3, 8'h01, 8'h02, 8'h10, 8'h02, 8'h00);
        @(negedge clk);
        tests_run++;
        if (if32.m_axis_tvalid !== 1'b1 || if32.m_axis_tdata !== 32'h4A4A0002) begin
            tests_failed++;
            $display("FAIL mid_beat1: valid=%b data=%h, want 1 4a4a0002",
                     if32.m_axis_tvalid, if32.m_axis_tdata);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (if32.m_axis_tvalid !== 1'b0 || if32.m_axis_tlast !== 1'b0 || if32.m_axis_tdata !== 32'h0 ||
            busy32 !== 1'b0 || if32.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset: valid=%b last=%b data=%h busy=%b ready=%b, want 0 0 0 0 1",
                     if32.m_axis_tvalid, if32.m_axis_tlast, if32.m_axis_tdata, busy32, if32.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req32(3'd3, 8'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        capture32(40, 1'b0, 0);
        tests_run++;
        if (cap_d.size() != 1 || done_cnt != 1 || cap_d[0] !== 32'h7C7C7CBC || cap_k[0] !== 4'b1111 ||
            cap_l[0] !== 1'b1 || cap_u[0] !== 2'b00) begin
            tests_failed++;
            $display("FAIL eios_after_reset: beats=%0d done_cnt=%0d data=%h k=%b last=%b, want 1 1 7c7c7cbc 1111 1",
                     cap_d.size(), done_cnt, (cap_d.size() > 0) ? cap_d[0] : 32'h0,
                     (cap_k.size() > 0) ? cap_k[0] : 4'h0, (cap_l.size() > 0) ? cap_l[0] : 1'b0);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        stop32 = 1'b0; stop8 = 1'b0;
        if32.req_valid = 1'b0; if32.req_type = 3'd0; if32.req_count = 8'd0;
        if32.req_link_num = 8'd0; if32.req_lane_num = 8'd0; if32.req_n_fts = 8'd0;
        if32.req_rate_id = 8'd0; if32.req_train_ctl = 8'd0; if32.m_axis_tready = 1'b1;
        if8.req_valid = 1'b0; if8.req_type = 3'd0; if8.req_count = 8'd0;
        if8.req_link_num = 8'd0; if8.req_lane_num = 8'd0; if8.req_n_fts = 8'd0;
        if8.req_rate_id = 8'd0; if8.req_train_ctl = 8'd0; if8.m_axis_tready = 1'b1;
        @(negedge clk);
        test_reset();
        test_ts1_pad_count2();
        test_ts2_width8();
        test_skp_continuous_stop();
        test_eieos_backpressure();
        test_invalid_type();
        test_reset_mid_then_eios();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
